// File: rtl/extend_pipe.sv
// Immediate extension for RV32/RV64 instruction formats, buffered through a
// 2-entry valid/ready FIFO that holds {imm_ext, err} with one cycle of latency.
module extend_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [24:0]      imm_i,
  input  logic [2:0]       immsrc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_ext_o,
  output logic             err_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int ENT_W = XLEN + 1;

  logic [31:0]      w_raw_p0;
  logic [XLEN-1:0]  w_ext_p0;
  logic             w_err_p0;
  logic             w_push;
  logic             w_pop;
  logic [ENT_W-1:0] w_head_p1;

  logic [ENT_W-1:0] r_mem_p1 [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_occ;
  logic [CNT_W-1:0] r_count;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0]   s;
    logic signed [XLEN-1:0] w;
    s = v;
    w = XLEN'(s);
    return w;
  endfunction

  // Stage p0: combinational extension of the incoming instruction fields
  always_comb begin
    w_raw_p0 = '0;
    w_err_p0 = 1'b0;
    case (immsrc_i)
      3'b000: w_raw_p0 = {{20{imm_i[24]}}, imm_i[24:13]};
      3'b001: w_raw_p0 = {{20{imm_i[24]}}, imm_i[24:18], imm_i[4:0]};
      3'b010: w_raw_p0 = {{19{imm_i[24]}}, imm_i[24], imm_i[0], imm_i[23:18],
                          imm_i[4:1], 1'b0};
      3'b011: w_raw_p0 = {imm_i[24:5], 12'b0};
      3'b100: w_raw_p0 = {{11{imm_i[24]}}, imm_i[24], imm_i[12:5], imm_i[13],
                          imm_i[23:14], 1'b0};
      default: w_err_p0 = 1'b1;
    endcase
    w_ext_p0 = w_err_p0 ? '0 : sext32(w_raw_p0);
  end

  assign in_ready_o  = (r_occ < 2'd2);
  assign out_valid_o = (r_occ != 2'd0);
  assign w_push      = in_valid_i && in_ready_o;
  assign w_pop       = out_valid_o && out_ready_i;

  // Stage p1: FIFO storage; contents are never reset, only the control state
  always_ff @(posedge clk_i) begin
    if (w_push && !rst_i) begin
      r_mem_p1[r_wptr] <= {w_ext_p0, w_err_p0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_occ   <= 2'd0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr  <= ~r_wptr;
        r_count <= r_count + CNT_W'(1);
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Head is masked while empty so stale storage never leaks to the outputs
  assign w_head_p1 = r_mem_p1[r_rptr];
  assign imm_ext_o = out_valid_o ? w_head_p1[ENT_W-1:1] : '0;
  assign err_o     = out_valid_o ? w_head_p1[0] : 1'b0;
  assign count_o   = r_count;

endmodule
